// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - sequential AES-128 key schedule, one round key per valid/ready handshake
module key_expansion_seq #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [0:KEY_W-1] keyIn,
  output logic [0:31]      rconRound,
  input  logic [0:31]      rconValue,
  output logic [0:31]      subWordIn,
  input  logic [0:31]      subWordOut,
  output logic [0:KEY_W-1] roundKey,
  output logic [3:0]       roundIdx,
  output logic             keyValid,
  input  logic             keyReady,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state, state_next;
  logic        handshake, last_key;
  logic [0:31] w0, w1, w2, w3;
  logic [0:31] temp, n0, n1, n2, n3;

  assign w0 = roundKey[0:31];
  assign w1 = roundKey[32:63];
  assign w2 = roundKey[64:95];
  assign w3 = roundKey[96:127];

  assign handshake = keyValid & keyReady;
  assign last_key  = (roundIdx == 4'(NR));

  // Rcon lookup index runs one ahead of the key being presented
  assign rconRound = {28'b0, roundIdx + 4'd1};
  assign subWordIn = {w3[8:31], w3[0:7]};

  assign temp = subWordOut ^ rconValue;
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      roundKey <= '0;
      roundIdx <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == EXPAND) && handshake && last_key;
      if (state == IDLE && start) begin
        roundKey <= keyIn;
        roundIdx <= '0;
      end else if (state == EXPAND && handshake && !last_key) begin
        roundKey <= {n0, n1, n2, n3};
        roundIdx <= roundIdx + 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (handshake && last_key) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    keyValid = (state == EXPAND);
    busy     = (state == EXPAND);
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - bench for key_expansion_seq with GF(2^8) S-box/Rcon and word-level key schedule model
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst_n, start, keyReady;
  logic [0:127] keyIn, roundKey;
  logic [0:31]  rconRound, rconValue, subWordIn, subWordOut;
  logic [3:0]   roundIdx;
  logic         keyValid, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] acc_rk [0:10];
  int           acc_n, done_cyc, valid_cycles;
  bit           done_seen;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [6];

  key_expansion_seq #(.NR(10), .KEY_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .keyIn(keyIn),
    .rconRound(rconRound), .rconValue(rconValue),
    .subWordIn(subWordIn), .subWordOut(subWordOut),
    .roundKey(roundKey), .roundIdx(roundIdx),
    .keyValid(keyValid), .keyReady(keyReady),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv = 8'h01;
    logic [7:0] s, r;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    if (b == 8'h00) inv = 8'h00;
    s = inv;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [31:0] r);
    logic [7:0] x = 8'h01;
    if (r < 1 || r > 10) return 8'h00;
    for (int i = 1; i < int'(r); i++) x = xtime(x);
    return x;
  endfunction

  always_comb begin
    subWordOut = sub_word(subWordIn);
    rconValue  = {rcon_of(rconRound), 24'h000000};
  end

  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(32'(i / 4)), 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // mode 0: ready always 1, mode 1: ready 1,0,0 repeating, mode 2: random ready
  task automatic run_expand(input logic [127:0] key, input int mode, input bit inject, input int abort_idx);
    bit           held = 0;
    bit           rdy;
    logic [127:0] hold_key;
    logic [3:0]   hold_idx;
    int           p = 0;
    expand_ref(key);
    @(negedge clk);
    start = 1'b1; keyIn = key; keyReady = 1'b0;
    acc_n = 0; done_seen = 0; done_cyc = 0; valid_cycles = 0;
    for (int cyc = 1; cyc <= 200 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      keyIn = {$urandom, $urandom, $urandom, $urandom};
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        check("done_after_all_keys", 128'(acc_n), 128'd11);
      end else if (keyValid) begin
        valid_cycles++;
        if (abort_idx >= 0 && acc_n == abort_idx) begin
          rst_n = 1'b0;
          #1;
          check("abort_roundKey", roundKey, 128'd0);
          check("abort_idx_valid_busy_done", {roundIdx, keyValid, busy, done}, 128'd0);
          check("abort_rconRound", rconRound, 128'd1);
          @(negedge clk);
          check("abort_no_done", {done, keyValid}, 128'd0);
          rst_n = 1'b1; keyReady = 1'b0;
          return;
        end
        check("busy_with_valid", busy, 1'b1);
        if (held) begin
          check("hold_key", roundKey, hold_key);
          check("hold_idx", roundIdx, hold_idx);
        end
        check("round_idx", roundIdx, 128'(acc_n));
        check("rcon_round", rconRound, 128'(acc_n + 1));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (p % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        p++;
        keyReady = rdy;
        if (inject && (acc_n == 3 || (acc_n == 10 && rdy))) start = 1'b1;
        if (rdy) begin
          if (acc_n <= 10) acc_rk[acc_n] = roundKey;
          acc_n++;
          held = 0;
        end else begin
          held = 1; hold_key = roundKey; hold_idx = roundIdx;
        end
        if (acc_n > 11) begin
          check("too_many_keys", 128'(acc_n), 128'd11);
          break;
        end
      end
    end
    keyReady = 1'b0;
    start = 1'b0;
    check("done_seen", 128'(done_seen), 128'd1);
    @(negedge clk);
    check("done_one_cycle", {done, keyValid, busy}, 128'd0);
    if (mode == 0) begin
      check("done_latency", 128'(done_cyc), 128'd12);
      check("valid_cycles", 128'(valid_cycles), 128'd11);
    end
    for (int r = 0; r <= 10; r++)
      if (r < acc_n) check($sformatf("round_key_%0d", r), acc_rk[r], exp_rk[r]);
      else check($sformatf("missing_key_%0d", r), 128'(acc_n), 128'd11);
  endtask

  initial begin
    vecs[0] = '{"fips_r0",  128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{"fips_r1",  128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{"fips_r10", 128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{"seq_r1",   128'h000102030405060708090a0b0c0d0e0f, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[4] = '{"zero_r1",  128'h0,                                1,  128'h62636363626363636263636362636363};
    vecs[5] = '{"zero_r10", 128'h0,                                10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_n = 1'b0; start = 1'b0; keyReady = 1'b0; keyIn = '0;
    repeat (2) @(negedge clk);
    check("reset_roundKey", roundKey, 128'd0);
    check("reset_idx_valid_busy_done", {roundIdx, keyValid, busy, done}, 128'd0);
    check("reset_rconRound", rconRound, 128'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {keyValid, busy, done}, 128'd0);

    for (int i = 0; i < 6; i++) begin
      run_expand(vecs[i].key, 0, 0, -1);
      check(vecs[i].name, acc_rk[vecs[i].idx], vecs[i].rk);
    end

    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 0, -1);
    check("toggle_r10", acc_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1, -1);
    run_expand(128'h000102030405060708090a0b0c0d0e0f, 0, 0, -1);
    check("restart_seq_r1", acc_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 5);
    run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, -1);
    check("post_reset_r1", acc_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

    repeat (8) begin
      run_expand({$urandom, $urandom, $urandom, $urandom}, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
